// File: rtl/edge_update_scheduler.sv
// Edge-update scheduler: buffers host-written rate-edge updates in a FIFO and
// feeds them one at a time to the Bellman-Ford container (load, reset pulse, run).
module edge_update_scheduler #(
  parameter int NODE_W     = 6,
  parameter int WEIGHT_W   = 32,
  parameter int DEPTH      = 8,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       chipselect,
  input  logic                       write,
  input  logic [2:0]                 address,
  input  logic [WEIGHT_W-1:0]        writedata,
  input  logic                       container_done,
  output logic [NODE_W-1:0]          u_src,
  output logic [NODE_W-1:0]          u_dst,
  output logic [WEIGHT_W-1:0]        u_e,
  output logic                       container_reset,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow,
  output logic                       timeout,
  output logic                       update_done
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef struct packed {
    logic [NODE_W-1:0]   src;
    logic [NODE_W-1:0]   dst;
    logic [WEIGHT_W-1:0] e;
  } upd_t;

  typedef enum logic [2:0] {IDLE, LOAD, RST, RUN, DONE} state_t;

  state_t            state, state_nxt;
  upd_t              mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [NODE_W-1:0] stg_src, stg_dst;
  logic [RC_W-1:0]   rst_cnt;
  logic [WD_W-1:0]   wd_cnt;
  logic              host_wr, push_req, push, pop, full, tmo_set;

  assign host_wr  = chipselect && write;
  assign push_req = host_wr && (address == 3'd1);
  assign pop      = (state == LOAD);
  assign full     = (fifo_count == CW'(DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push     = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{src: stg_src, dst: stg_dst, e: writedata};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      stg_src    <= '0;
      stg_dst    <= '0;
      overflow   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      fifo_count <= fifo_count + CW'(1);
      else if (pop && !push) fifo_count <= fifo_count - CW'(1);
      if (host_wr && address == 3'd0) begin
        stg_src <= writedata[2*NODE_W-1:NODE_W];
        stg_dst <= writedata[NODE_W-1:0];
      end
      if (push_req && !push)                         overflow <= 1'b1;
      else if (host_wr && address == 3'd2 && writedata[0]) overflow <= 1'b0;
      if (tmo_set)                                   timeout <= 1'b1;
      else if (host_wr && address == 3'd2 && writedata[1]) timeout <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rst_cnt <= '0;
      wd_cnt  <= '0;
      u_src   <= '0;
      u_dst   <= '0;
      u_e     <= '0;
    end else begin
      state   <= state_nxt;
      rst_cnt <= (state == RST) ? rst_cnt + RC_W'(1) : '0;
      // Saturating so a disabled watchdog never wraps back to the first-cycle value.
      if (state != RUN)       wd_cnt <= '0;
      else if (wd_cnt != '1)  wd_cnt <= wd_cnt + WD_W'(1);
      if (pop) begin
        u_src <= mem[rd_ptr].src;
        u_dst <= mem[rd_ptr].dst;
        u_e   <= mem[rd_ptr].e;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    tmo_set   = 1'b0;
    case (state)
      IDLE: if (fifo_count != '0) state_nxt = LOAD;
      LOAD: state_nxt = RST;
      RST:  if (rst_cnt == RC_LAST) state_nxt = RUN;
      RUN: begin
        // Done is only trusted once the container has seen a full cycle out of reset.
        if (container_done && wd_cnt != '0) state_nxt = DONE;
        else if (TIMEOUT != 0 && wd_cnt == WD_LAST) begin
          tmo_set   = 1'b1;
          state_nxt = IDLE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign container_reset = (state == RST);
  assign update_done     = (state == DONE);
  assign busy            = (state != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_edge_update_scheduler.sv
// Directed bench for edge_update_scheduler (DEPTH=8, RST_CYCLES=2, TIMEOUT=16).
module tb_edge_update_scheduler;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0, write = 1'b0, container_done = 1'b0;
  logic [2:0]  address = '0;
  logic [31:0] writedata = '0;
  logic [5:0]  u_src, u_dst;
  logic [31:0] u_e;
  logic        container_reset, busy, overflow, timeout, update_done;
  logic [3:0]  fifo_count;
  int tests = 0, fails = 0;

  edge_update_scheduler #(.NODE_W(6), .WEIGHT_W(32), .DEPTH(8), .RST_CYCLES(2), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .address(address),
    .writedata(writedata), .container_done(container_done), .u_src(u_src), .u_dst(u_dst),
    .u_e(u_e), .container_reset(container_reset), .busy(busy), .fifo_count(fifo_count),
    .overflow(overflow), .timeout(timeout), .update_done(update_done));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic host_wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    step();
    chipselect = 1'b0; write = 1'b0; address = '0; writedata = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b1; #3; reset = 1'b0; step();
  endtask

  task automatic test_reset();
    reset = 1'b1; step();
    tests++; if ({u_src, u_dst, u_e, container_reset, busy, fifo_count, overflow, timeout, update_done} !== '0) begin
      fails++; $display("FAIL reset_outputs: got %0h expected 0",
        {u_src, u_dst, u_e, container_reset, busy, fifo_count, overflow, timeout, update_done}); end
    reset = 1'b0; step();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_single_update();
    apply_reset();
    host_wr(3'd0, (32'd3 << 6) | 32'd5);
    host_wr(3'd1, 32'h10);
    tests++; if (fifo_count !== 4'd1 || busy !== 1'b1) begin fails++; $display("FAIL su_queued: got cnt=%0d busy=%0b expected cnt=1 busy=1", fifo_count, busy); end
    step(); // LOAD
    tests++; if (fifo_count !== 4'd1 || container_reset !== 1'b0) begin fails++; $display("FAIL su_load: got cnt=%0d crst=%0b expected cnt=1 crst=0", fifo_count, container_reset); end
    step(); // RST 1
    tests++; if (fifo_count !== 4'd0 || container_reset !== 1'b1) begin fails++; $display("FAIL su_rst1: got cnt=%0d crst=%0b expected cnt=0 crst=1", fifo_count, container_reset); end
    tests++; if ({u_src, u_dst, u_e} !== {6'd3, 6'd5, 32'h10}) begin fails++; $display("FAIL su_edge: got src=%0d dst=%0d e=%0h expected 3 5 10", u_src, u_dst, u_e); end
    step(); // RST 2
    tests++; if (container_reset !== 1'b1) begin fails++; $display("FAIL su_rst2: got %0b expected 1", container_reset); end
    container_done = 1'b1;
    step(); // RUN first cycle
    tests++; if (container_reset !== 1'b0 || update_done !== 1'b0) begin fails++; $display("FAIL su_run1: got crst=%0b ud=%0b expected 0 0", container_reset, update_done); end
    step(); // RUN second cycle, done from first cycle ignored
    tests++; if (update_done !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL su_run2: got ud=%0b busy=%0b expected 0 1", update_done, busy); end
    step(); // DONE
    tests++; if (update_done !== 1'b1) begin fails++; $display("FAIL su_done: got %0b expected 1", update_done); end
    container_done = 1'b0;
    step(); // IDLE
    tests++; if (update_done !== 1'b0 || busy !== 1'b0 || u_e !== 32'h10) begin fails++; $display("FAIL su_after: got ud=%0b busy=%0b e=%0h expected 0 0 10", update_done, busy, u_e); end
  endtask

  task automatic test_overflow();
    logic [3:0] exp_cnt;
    apply_reset();
    host_wr(3'd0, (32'd1 << 6) | 32'd2);
    host_wr(3'd1, 32'hA0);
    step(); step(); // LOAD, then RST
    tests++; if (container_reset !== 1'b1 || fifo_count !== 4'd0) begin fails++; $display("FAIL ov_running: got crst=%0b cnt=%0d expected 1 0", container_reset, fifo_count); end
    host_wr(3'd0, (32'd7 << 6) | 32'd9);
    for (int i = 0; i < 9; i++) begin
      host_wr(3'd1, 32'h100 + i);
      exp_cnt = (i < 8) ? 4'(i + 1) : 4'd8;
      tests++; if (fifo_count !== exp_cnt || overflow !== (i == 8)) begin fails++; $display("FAIL ov_push%0d: got cnt=%0d ovf=%0b expected cnt=%0d ovf=%0b", i, fifo_count, overflow, exp_cnt, (i == 8)); end
    end
    host_wr(3'd2, 32'd1);
    tests++; if (overflow !== 1'b0 || timeout !== 1'b0) begin fails++; $display("FAIL ov_clear: got ovf=%0b tmo=%0b expected 0 0", overflow, timeout); end
  endtask

  task automatic test_push_on_full_pop();
    for (int n = 0; n < 40 && timeout !== 1'b1; n++) step();
    tests++; if (timeout !== 1'b1 || update_done !== 1'b0) begin fails++; $display("FAIL fp_wait_tmo: got tmo=%0b ud=%0b expected 1 0", timeout, update_done); end
    step(); // LOAD
    tests++; if (fifo_count !== 4'd8 || container_reset !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL fp_load: got cnt=%0d crst=%0b busy=%0b expected 8 0 1", fifo_count, container_reset, busy); end
    host_wr(3'd1, 32'h200); // lands on the pop edge
    tests++; if (fifo_count !== 4'd8 || overflow !== 1'b0) begin fails++; $display("FAIL fp_pushpop: got cnt=%0d ovf=%0b expected 8 0", fifo_count, overflow); end
    tests++; if ({u_src, u_dst, u_e, container_reset} !== {6'd7, 6'd9, 32'h100, 1'b1}) begin fails++; $display("FAIL fp_edge: got src=%0d dst=%0d e=%0h crst=%0b expected 7 9 100 1", u_src, u_dst, u_e, container_reset); end
    host_wr(3'd2, 32'd2);
    tests++; if (timeout !== 1'b0 || overflow !== 1'b0) begin fails++; $display("FAIL fp_tmo_clear: got tmo=%0b ovf=%0b expected 0 0", timeout, overflow); end
  endtask

  task automatic test_timeout();
    for (int n = 0; n < 8 && container_reset !== 1'b0; n++) step();
    tests++; if (container_reset !== 1'b0) begin fails++; $display("FAIL to_run_entry: got crst=%0b expected 0", container_reset); end
    for (int k = 1; k <= 16; k++) begin
      step();
      tests++; if ({timeout, update_done} !== {(k == 16), 1'b0}) begin fails++; $display("FAIL to_cycle%0d: got tmo=%0b ud=%0b expected tmo=%0b ud=0", k, timeout, update_done, (k == 16)); end
    end
    tests++; if (busy !== 1'b1 || u_e !== 32'h100) begin fails++; $display("FAIL to_hold: got busy=%0b e=%0h expected 1 100", busy, u_e); end
    step(); step(); // LOAD, RST
    tests++; if (container_reset !== 1'b1 || u_e !== 32'h101 || fifo_count !== 4'd7) begin fails++; $display("FAIL to_next: got crst=%0b e=%0h cnt=%0d expected 1 101 7", container_reset, u_e, fifo_count); end
  endtask

  task automatic test_reset_mid_rst();
    apply_reset();
    host_wr(3'd0, (32'd2 << 6) | 32'd4);
    for (int i = 0; i < 4; i++) host_wr(3'd1, 32'h30 + i);
    tests++; if (container_reset !== 1'b1 || fifo_count !== 4'd3) begin fails++; $display("FAIL mr_setup: got crst=%0b cnt=%0d expected 1 3", container_reset, fifo_count); end
    #2; reset = 1'b1; #1;
    tests++; if ({u_src, u_dst, u_e, container_reset, busy, fifo_count, overflow, timeout, update_done} !== '0) begin
      fails++; $display("FAIL mr_outputs: got %0h expected 0",
        {u_src, u_dst, u_e, container_reset, busy, fifo_count, overflow, timeout, update_done}); end
    #2; reset = 1'b0;
    step(); step();
    tests++; if (busy !== 1'b0 || fifo_count !== 4'd0) begin fails++; $display("FAIL mr_after: got busy=%0b cnt=%0d expected 0 0", busy, fifo_count); end
  endtask

  task automatic test_idle_done();
    container_done = 1'b1; step(); container_done = 1'b0;
    tests++; if ({update_done, busy, container_reset, fifo_count} !== '0) begin fails++; $display("FAIL id_done1: got %0h expected 0", {update_done, busy, container_reset, fifo_count}); end
    step();
    tests++; if ({update_done, busy, container_reset, fifo_count} !== '0) begin fails++; $display("FAIL id_done2: got %0h expected 0", {update_done, busy, container_reset, fifo_count}); end
    host_wr(3'd5, 32'hFFF);
    tests++; if (fifo_count !== 4'd0 || busy !== 1'b0) begin fails++; $display("FAIL id_badaddr: got cnt=%0d busy=%0b expected 0 0", fifo_count, busy); end
  endtask

  initial begin
    test_reset();
    test_single_update();
    test_overflow();
    test_push_on_full_pop();
    test_timeout();
    test_reset_mid_rst();
    test_idle_done();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
